serial_spi_sequencer: RTL and testbench

Frame sequencer between the UART byte receiver and the SPI master in the serial-to-SPI bridge. Consumes received bytes, parses `0xA5, N, payload[N]` command frames into a local buffer, then drives the SPI master one byte at a time while holding chip-select low across the whole frame. Rejects malformed or overrun frames with an error pulse.

---
 rtl/serial_spi_sequencer.sv | 152 +++++++++++++++
 tb/tb_serial_spi_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_spi_sequencer.sv
// serial_spi_sequencer: parses 0xA5,N,payload[N] frames from a byte stream and replays them to an SPI master
//   clk_50, rst_n     : clock, asynchronous active-low reset
//   LOAD, BYTE_IN     : received byte strobe (level, rising edge = new byte) and data
//   SPI_BUSY          : SPI master transfer in progress
//   SPI_START/SPI_DATA: one-cycle transmit request and the byte to send
//   SPI_CS_N          : slave select, low for the whole frame
//   BUSY/DONE/FRAME_ERR: not idle / frame finished pulse / frame rejected pulse
//   Define SEQ_TIMEOUT_EN to abort a frame stalled in LEN or FILL after TIMEOUT_CYC cycles.
module serial_spi_sequencer #(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       LOAD,
  input  logic [7:0] BYTE_IN,
  input  logic       SPI_BUSY,
  output logic       SPI_START,
  output logic [7:0] SPI_DATA,
  output logic       SPI_CS_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       FRAME_ERR
);
  typedef enum logic [2:0] {IDLE, LEN, FILL, ISSUE, WAIT_HI, WAIT_LO, CLOSE} state_t;
  state_t state_q, state_d;
  logic [3:0] len_q, len_d, widx_q, widx_d, ridx_q, ridx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] buf_q [16];
  logic load_q, start_q, start_d, cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic ev, buf_we, tmo, stalled;
  assign ev      = LOAD & ~load_q;
  assign stalled = (state_q == LEN) || (state_q == FILL);
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
  assign to_d = (ev || !stalled) ? '0 : to_q + 1'b1;
  assign tmo  = stalled && (to_q == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
`else
  // never true for a legal TIMEOUT_CYC: timeout disabled
  assign tmo = (TIMEOUT_CYC < 0);
`endif
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      IDLE: state_d = (ev && BYTE_IN == 8'hA5) ? LEN : IDLE;
      LEN: begin
        if (ev) begin
          // length is range-checked on the full byte before truncation to 4 bits
          if (BYTE_IN == 8'd0 || BYTE_IN > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = BYTE_IN[3:0];
            widx_d  = 4'd0;
            state_d = FILL;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      FILL: begin
        if (ev) begin
          buf_we = 1'b1;
          widx_d = widx_q + 4'd1;
          if (widx_q + 4'd1 == len_q) begin
            ridx_d  = 4'd0;
            cs_n_d  = 1'b0;
            state_d = ISSUE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!SPI_BUSY) begin
          data_d  = buf_q[ridx_q];
          start_d = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: state_d = SPI_BUSY ? WAIT_LO : WAIT_HI;
      WAIT_LO: begin
        if (!SPI_BUSY) begin
          ridx_d = ridx_q + 4'd1;
          // CS release and DONE are registered on entry to CLOSE so they appear one cycle after BUSY falls
          if (ridx_q + 4'd1 == len_q) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = CLOSE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // bytes arriving while the frame is being replayed are dropped as overruns
    if (ev && (state_q inside {ISSUE, WAIT_HI, WAIT_LO, CLOSE})) err_d = 1'b1;
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= 4'd0;
      widx_q  <= 4'd0;
      ridx_q  <= 4'd0;
      data_q  <= 8'h00;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      data_q  <= data_d;
      load_q  <= LOAD;
      start_q <= start_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  // payload buffer needs no reset; its contents are don't-care after an abort
  always_ff @(posedge clk_50)
    if (buf_we) buf_q[widx_q] <= BYTE_IN;
  assign SPI_START = start_q;
  assign SPI_DATA  = data_q;
  assign SPI_CS_N  = cs_n_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FRAME_ERR = err_q;
endmodule

// File: tb/tb_serial_spi_sequencer.sv
// tb_serial_spi_sequencer: scoreboard bench for serial_spi_sequencer with a simple SPI master model
module tb_serial_spi_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, spi_busy = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic spi_start, cs_n, busy, done, ferr;
  logic [7:0] spi_data;
  int checks = 0, failures = 0;
  logic [9:0] sb [$];
  localparam logic [1:0] K_START = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

  always #10 clk = ~clk;

  serial_spi_sequencer #(.MAX_LEN(8), .TIMEOUT_CYC(100)) dut (
    .clk_50(clk), .rst_n(rst_n), .LOAD(load), .BYTE_IN(byte_in), .SPI_BUSY(spi_busy),
    .SPI_START(spi_start), .SPI_DATA(spi_data), .SPI_CS_N(cs_n), .BUSY(busy),
    .DONE(done), .FRAME_ERR(ferr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_chk(input string name, input logic [9:0] act);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected act=%h exp=none t=%0t", name, act, $time);
    end else begin
      logic [9:0] e;
      e = sb.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s act=%h exp=%h t=%0t", name, act, e, $time);
      end
    end
  endtask

  task automatic exp_start(input logic [7:0] b); sb.push_back({K_START, b}); endtask
  task automatic exp_done(); sb.push_back({K_DONE, 8'h00}); endtask
  task automatic exp_err();  sb.push_back({K_ERR, 8'h00}); endtask

  // monitor: every output pulse is matched against the scoreboard in start/done/err order
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (spi_start) begin
        sb_chk("start", {K_START, spi_data});
        chk("start_cs_low", 32'(cs_n), 32'd0);
      end
      if (done) begin
        sb_chk("done", {K_DONE, 8'h00});
        chk("done_cs_high", 32'(cs_n), 32'd1);
      end
      if (ferr) sb_chk("frame_err", {K_ERR, 8'h00});
    end
  end

  // SPI master model: BUSY rises one cycle after START and stays high 20 cycles
  initial forever begin
    @(negedge clk);
    if (rst_n && spi_start) begin
      @(negedge clk);
      spi_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!rst_n) break;
      end
      spi_busy = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (spi_start) break;
    end
    chk({name, "_start_seen"}, 32'(n < 500), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy && !spi_busy) break;
    end
    chk({name, "_idle_reached"}, 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
    chk({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    chk({name, "_cs_high"}, 32'(cs_n), 32'd1);
  endtask

  initial begin
    logic [7:0] p [8];
    p = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h7F, 8'hC3};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_data", 32'(spi_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(ferr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // basic three-byte frame
    exp_start(8'h11); exp_start(8'h22); exp_start(8'h33); exp_done();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    wait_idle("t1");
    // junk ignored, zero length rejected
    exp_err();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
    chk("t2_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);
    // oversize length rejected, then maximum-length frame with 0xA5 as data
    exp_err();
    send(8'hA5); send(8'h09);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_cs_n", 32'(cs_n), 32'd1);
    repeat (2) @(negedge clk);
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 8; i++) exp_start(p[i]);
    exp_done();
    send(8'hA5); send(8'h08);
    for (int i = 0; i < 8; i++) send(p[i]);
    chk("t3_cs_setup", 32'(cs_n), 32'd0);
    wait_idle("t3");
    // overrun byte during WAIT_LO of first byte
    exp_start(8'h01); exp_err(); exp_start(8'h02); exp_done();
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02);
    wait_start("t4");
    repeat (5) @(negedge clk);
    send(8'h44);
    wait_idle("t4");
    // reset during WAIT_LO of byte 2 of 3
    exp_start(8'h01); exp_start(8'h02);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    wait_start("t5a");
    wait_start("t5b");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cs_n", 32'(cs_n), 32'd1);
    chk("t5_rst_start", 32'(spi_start), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);
    exp_start(8'h7E); exp_done();
    send(8'hA5); send(8'h01); send(8'h7E);
    wait_idle("t5");
`ifdef SEQ_TIMEOUT_EN
    // stalled frame times out in FILL, then a full frame still works
    exp_err();
    send(8'hA5); send(8'h02); send(8'h10);
    repeat (105) @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);
    exp_start(8'h3C); exp_done();
    send(8'hA5); send(8'h01); send(8'h3C);
    wait_idle("t6");
`endif
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
